// File: rtl/tcdm_bank_pkg.sv
// Shared types and width helpers for the TCDM bank responder.
//
// Contents:
//   tcdm_bank_state_e : controller state (INIT = zeroizing the array, READY = serving requests)
//   off_width()       : number of byte-offset address bits for a given data width
//   idx_width()       : number of word-index address bits for a given address/data width
package tcdm_bank_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } tcdm_bank_state_e;

  function automatic int unsigned off_width(input int unsigned dw);
    return $clog2(dw / 8);
  endfunction

  function automatic int unsigned idx_width(input int unsigned aw, input int unsigned dw);
    return aw - off_width(dw);
  endfunction

endpackage

// File: rtl/tcdm_bank_array.sv
// Byte-enabled single-port word array with a registered read port.
//
// Each byte lane is its own narrow memory, so every lane maps onto a plain
// block RAM column and byte enables become per-lane write enables.
//
// Ports:
//   clk_i    : clock
//   rst_ni   : synchronous active-low reset of the read-data register only
//              (memory contents are never reset)
//   req_i    : access strobe
//   we_i     : 1 = write, 0 = read
//   valid_i  : address is inside the array; when 0 writes are dropped and
//              reads return zero
//   addr_i   : word address
//   wdata_i  : write data
//   be_i     : byte enables (writes only)
//   rdata_o  : read data, valid the cycle after a read; forced to zero after
//              a write, held while idle
module tcdm_bank_array #(
  parameter int unsigned DW       = 32,
  parameter int unsigned NumWords = 2048,
  parameter int unsigned LW       = 11
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              we_i,
  input  logic              valid_i,
  input  logic [LW-1:0]     addr_i,
  input  logic [DW-1:0]     wdata_i,
  input  logic [DW/8-1:0]   be_i,
  output logic [DW-1:0]     rdata_o
);

  localparam int unsigned NB = DW / 8;

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0] mem_q [NumWords];
    logic [7:0] rdata_q;

    always_ff @(posedge clk_i) begin
      if (req_i && we_i && valid_i && be_i[gi]) begin
        mem_q[addr_i] <= wdata_i[gi*8 +: 8];
      end
    end

    // Read-first: a read returns the contents before any write in the same
    // edge; a write access leaves zero on the read port.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        rdata_q <= '0;
      end else if (req_i) begin
        rdata_q <= (!we_i && valid_i) ? mem_q[addr_i] : 8'h00;
      end
    end

    assign rdata_o[gi*8 +: 8] = rdata_q;
  end

endmodule

// File: rtl/tcdm_bank_responder.sv
// TCDM bank responder: target-side endpoint of one HCI TCDM memory port.
//
// Accepts req/gnt requests, performs byte-enabled reads/writes on an internal
// word array and returns one response per grant exactly one cycle later,
// tagged with the request ID. After reset/clear the array is optionally
// zeroized (InitZero) before the first grant.
//
// Optional feature (macro TCDM_BANK_RESPONDER_STATS_EN): adds saturating
// 32-bit counters of granted reads (rd_cnt_o) and writes (wr_cnt_o).
//
// Ports:
//   clk_i       : clock
//   rst_ni      : synchronous active-low reset
//   clear_i     : synchronous soft clear (same effect as reset)
//   req_i/gnt_o : request valid / grant (gnt_o = req_i while READY)
//   add_i       : byte address
//   wen_i       : 1 = read, 0 = write
//   data_i      : write data
//   be_i        : byte enables
//   id_i        : request ID
//   r_valid_o   : response valid (one cycle after each grant)
//   r_data_o    : read data (zero for write responses)
//   r_id_o      : response ID
//   init_done_o : high while READY
module tcdm_bank_responder
  import tcdm_bank_pkg::*;
#(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 13,
  parameter int unsigned NumWords = 2048,
  parameter int unsigned IW       = 8,
  parameter bit          InitZero = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            req_i,
  output logic            gnt_o,
  input  logic [AW-1:0]   add_i,
  input  logic            wen_i,
  input  logic [DW-1:0]   data_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [IW-1:0]   id_i,
  output logic            r_valid_o,
  output logic [DW-1:0]   r_data_o,
  output logic [IW-1:0]   r_id_o,
  output logic            init_done_o
`ifdef TCDM_BANK_RESPONDER_STATS_EN
  ,
  output logic [31:0]     rd_cnt_o,
  output logic [31:0]     wr_cnt_o
`endif
);

  localparam int unsigned OffW = off_width(DW);
  localparam int unsigned IdxW = idx_width(AW, DW);
  localparam int unsigned LW   = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int unsigned NB   = DW / 8;

  // Reset and clear behave identically; fold them into one strobe.
  logic srst;
  assign srst = !rst_ni || clear_i;

  logic [IdxW-1:0] idx;
  logic            in_range;
  assign idx      = add_i[AW-1:OffW];
  assign in_range = ({1'b0, idx} < (IdxW + 1)'(NumWords));

  // Byte-offset bits select nothing inside a word-wide port.
  logic unused_offset;
  assign unused_offset = ^add_i[OffW-1:0];

  tcdm_bank_state_e state_q, state_d;
  logic [LW-1:0]    init_cnt_q, init_cnt_d;
  logic             r_valid_q;
  logic [IW-1:0]    r_id_q;

  logic             gnt;
  logic             arr_req;
  logic             arr_we;
  logic             arr_valid;
  logic [LW-1:0]    arr_addr;
  logic [DW-1:0]    arr_wdata;
  logic [NB-1:0]    arr_be;
  logic [DW-1:0]    arr_rdata;

  // Next-state logic and the 2:1 array-port mux between the zeroizer and
  // the request path. Nothing reaches the array in a reset/clear cycle.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    gnt        = 1'b0;
    arr_req    = 1'b0;
    arr_we     = 1'b0;
    arr_valid  = 1'b0;
    arr_addr   = idx[LW-1:0];
    arr_wdata  = data_i;
    arr_be     = be_i;
    if (!srst) begin
      case (state_q)
        INIT: begin
          arr_req    = 1'b1;
          arr_we     = 1'b1;
          arr_valid  = 1'b1;
          arr_addr   = init_cnt_q;
          arr_wdata  = '0;
          arr_be     = '1;
          init_cnt_d = init_cnt_q + LW'(1);
          if (init_cnt_q == LW'(NumWords - 1)) begin
            state_d = READY;
          end
        end
        READY: begin
          gnt       = req_i;
          arr_req   = req_i;
          arr_we    = !wen_i;
          arr_valid = in_range;
        end
        default: begin
          state_d = READY;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst) begin
      state_q    <= InitZero ? INIT : READY;
      init_cnt_q <= '0;
      r_valid_q  <= 1'b0;
      r_id_q     <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      r_valid_q  <= gnt;
      if (gnt) begin
        r_id_q <= id_i;
      end
    end
  end

  tcdm_bank_array #(
    .DW       (DW),
    .NumWords (NumWords),
    .LW       (LW)
  ) u_array (
    .clk_i   (clk_i),
    .rst_ni  (!srst),
    .req_i   (arr_req),
    .we_i    (arr_we),
    .valid_i (arr_valid),
    .addr_i  (arr_addr),
    .wdata_i (arr_wdata),
    .be_i    (arr_be),
    .rdata_o (arr_rdata)
  );

  assign gnt_o       = gnt;
  assign r_valid_o   = r_valid_q;
  assign r_id_o      = r_id_q;
  assign r_data_o    = arr_rdata;
  assign init_done_o = (state_q == READY);

`ifdef TCDM_BANK_RESPONDER_STATS_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  // Out-of-range accesses are still granted, so they are counted too.
  always_ff @(posedge clk_i) begin
    if (srst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (gnt) begin
      if (wen_i) begin
        if (rd_cnt_q != 32'hFFFF_FFFF) rd_cnt_q <= rd_cnt_q + 32'd1;
      end else begin
        if (wr_cnt_q != 32'hFFFF_FFFF) wr_cnt_q <= wr_cnt_q + 32'd1;
      end
    end
  end

  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
`endif

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Self-checking bench for tcdm_bank_responder (16-word configuration).
// Expected responses are queued when a request is driven and compared when
// the DUT answers; a reference word array tracks the bank contents.
module tb_tcdm_bank_responder;

  localparam int DW = 32;
  localparam int AW = 13;
  localparam int NW = 16;
  localparam int IW = 8;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic            clear_i;
  logic            req_i;
  logic            gnt_o;
  logic [AW-1:0]   add_i;
  logic            wen_i;
  logic [DW-1:0]   data_i;
  logic [DW/8-1:0] be_i;
  logic [IW-1:0]   id_i;
  logic            r_valid_o;
  logic [DW-1:0]   r_data_o;
  logic [IW-1:0]   r_id_o;
  logic            init_done_o;
`ifdef TCDM_BANK_RESPONDER_STATS_EN
  logic [31:0]     rd_cnt_o;
  logic [31:0]     wr_cnt_o;
  int unsigned     exp_rd = 0;
  int unsigned     exp_wr = 0;
`endif

  always #5 clk = ~clk;

  tcdm_bank_responder #(
    .DW       (DW),
    .AW       (AW),
    .NumWords (NW),
    .IW       (IW),
    .InitZero (1'b1)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .add_i       (add_i),
    .wen_i       (wen_i),
    .data_i      (data_i),
    .be_i        (be_i),
    .id_i        (id_i),
    .r_valid_o   (r_valid_o),
    .r_data_o    (r_data_o),
    .r_id_o      (r_id_o),
    .init_done_o (init_done_o)
`ifdef TCDM_BANK_RESPONDER_STATS_EN
    ,
    .rd_cnt_o    (rd_cnt_o),
    .wr_cnt_o    (wr_cnt_o)
`endif
  );

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } resp_t;

  resp_t         exp_q[$];
  resp_t         mon_e;
  logic [DW-1:0] mem_model [NW];
  int            checks   = 0;
  int            failures = 0;
  bit            mon_en   = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic zero_model();
    for (int i = 0; i < NW; i++) mem_model[i] = '0;
`ifdef TCDM_BANK_RESPONDER_STATS_EN
    exp_rd = 0;
    exp_wr = 0;
`endif
  endtask

  // Response monitor: a response is due exactly when something was queued
  // during the previous cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("r_valid", 64'(r_valid_o), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        if (r_valid_o) begin
          check_eq("r_id", 64'(r_id_o), 64'(mon_e.id));
          check_eq("r_data", 64'(r_data_o), 64'(mon_e.data));
          $display("resp id=0x%02h data=0x%08h (exp id=0x%02h data=0x%08h)",
                   r_id_o, r_data_o, mon_e.id, mon_e.data);
        end
      end
`ifdef TCDM_BANK_RESPONDER_STATS_EN
      check_eq("rd_cnt", 64'(rd_cnt_o), 64'(exp_rd));
      check_eq("wr_cnt", 64'(wr_cnt_o), 64'(exp_wr));
`endif
    end
  end

  // Drive one request for one cycle (entered right after a falling edge),
  // require a grant and queue the expected response.
  task automatic do_access(input logic wen, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic [DW/8-1:0] be,
                           input logic [IW-1:0] id);
    int    widx;
    resp_t e;
    req_i   = 1'b1;
    clear_i = 1'b0;
    wen_i   = wen;
    add_i   = addr;
    data_i  = data;
    be_i    = be;
    id_i    = id;
    #1;
    check_eq("gnt", 64'(gnt_o), 64'd1);
    widx = int'(addr) / (DW / 8);
    e.id = id;
    if (wen) begin
      e.data = (widx < NW) ? mem_model[widx] : '0;
`ifdef TCDM_BANK_RESPONDER_STATS_EN
      exp_rd++;
`endif
    end else begin
      e.data = '0;
      if (widx < NW) begin
        for (int b = 0; b < DW / 8; b++)
          if (be[b]) mem_model[widx][b*8 +: 8] = data[b*8 +: 8];
      end
`ifdef TCDM_BANK_RESPONDER_STATS_EN
      exp_wr++;
`endif
    end
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_i   = 1'b0;
    clear_i = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Expect the zeroizer to hold off grants for exactly NW cycles while req_i is high.
  task automatic expect_init(input string tag);
    for (int i = 0; i < NW; i++) begin
      #1;
      check_eq({tag, "_gnt_low"}, 64'(gnt_o), 64'd0);
      check_eq({tag, "_not_done"}, 64'(init_done_o), 64'd0);
      @(negedge clk);
    end
    #1;
    check_eq({tag, "_done"}, 64'(init_done_o), 64'd1);
  endtask

  task automatic do_clear();
    req_i   = 1'b1;
    wen_i   = 1'b1;
    clear_i = 1'b1;
    #1;
    check_eq("clear_blocks_gnt", 64'(gnt_o), 64'd0);
    zero_model();
    @(negedge clk);
    clear_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni  = 1'b0;
    clear_i = 1'b0;
    req_i   = 1'b1;
    wen_i   = 1'b1;
    add_i   = '0;
    data_i  = '0;
    be_i    = '0;
    id_i    = '0;
    repeat (3) @(negedge clk);

    check_eq("rst_r_valid", 64'(r_valid_o), 64'd0);
    check_eq("rst_r_data", 64'(r_data_o), 64'd0);
    check_eq("rst_r_id", 64'(r_id_o), 64'd0);
    check_eq("rst_gnt", 64'(gnt_o), 64'd0);
    check_eq("rst_init_done", 64'(init_done_o), 64'd0);

    // Zeroization with req_i held high, then read back every word (be ignored).
    rst_ni = 1'b1;
    zero_model();
    mon_en = 1'b1;
    expect_init("init");
    for (int i = 0; i < NW; i++) do_access(1'b1, AW'(i * 4), '0, 4'h0, IW'(i));
    idle(2);

    // Byte enables, then r_data_o must hold after the response.
    do_access(1'b0, 13'h008, 32'hDEADBEEF, 4'b1111, 8'h20);
    do_access(1'b0, 13'h008, 32'h00000055, 4'b0001, 8'h21);
    do_access(1'b1, 13'h008, 32'h0, 4'b0000, 8'h22);
    idle(2);
    check_eq("r_data_hold", 64'(r_data_o), 64'h00000000DEADBE55);

    // Fill with random data back-to-back, then stream 8 reads with IDs 0..7.
    for (int i = 0; i < NW; i++)
      if (i != 2) do_access(1'b0, AW'(i * 4), $urandom, 4'hF, IW'(8'h40 + i));
    for (int i = 0; i < 8; i++) do_access(1'b1, AW'(i * 4), '0, 4'hF, IW'(i));
    idle(2);

    // Read-after-write on consecutive cycles (0x40 is out of range with 16
    // words, so the last in-range word 0x3C is used here).
    do_access(1'b0, 13'h03C, 32'h12345678, 4'hF, 8'h50);
    do_access(1'b1, 13'h03C, 32'h0, 4'hF, 8'h51);
    idle(1);

    // Out-of-range: word index NumWords and the top of the address space.
    do_access(1'b1, 13'h040, 32'h0, 4'hF, 8'h60);
    do_access(1'b0, 13'h040, 32'hFFFFFFFF, 4'hF, 8'h61);
    do_access(1'b1, 13'h040, 32'h0, 4'hF, 8'h62);
    do_access(1'b0, 13'h1FFC, 32'hA5A5A5A5, 4'hF, 8'h63);
    do_access(1'b1, 13'h000, 32'h0, 4'hF, 8'h64);
    idle(2);

    // Clear in READY with a read just granted, then clear again mid-INIT.
    do_access(1'b1, 13'h008, 32'h0, 4'hF, 8'h70);
    do_clear();
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("clr_init_gnt_low", 64'(gnt_o), 64'd0);
      @(negedge clk);
    end
    do_clear();
    expect_init("reinit");
    do_access(1'b1, 13'h008, 32'h0, 4'hF, 8'h71);
    do_access(1'b1, 13'h03C, 32'h0, 4'hF, 8'h72);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
